food_placer: RTL and testbench

FOOD_PLACER -- requirements
Module: food_placer

---
 rtl/food_placer_if.sv | 28 ++
 rtl/food_placer.sv | 182 ++++++++++++++++++
 tb/tb_food_placer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/food_placer_if.sv
// Request/lookup/result bundle between a game controller and the food placer.
// The placer drives the query and result signals; the controller answers
// occupancy lookups and issues requests/aborts.
interface food_placer_if;
    logic       i_Req;
    logic       i_Abort;
    logic       i_Occupied;
    logic       o_Query_Valid;
    logic [5:0] o_Query_X;
    logic [5:0] o_Query_Y;
    logic [5:0] o_Food_X;
    logic [5:0] o_Food_Y;
    logic       o_Valid;
    logic       o_Fail;
    logic       o_Busy;

    modport slave (
        input  i_Req, i_Abort, i_Occupied,
        output o_Query_Valid, o_Query_X, o_Query_Y,
        output o_Food_X, o_Food_Y, o_Valid, o_Fail, o_Busy
    );

    modport master (
        output i_Req, i_Abort, i_Occupied,
        input  o_Query_Valid, o_Query_X, o_Query_Y,
        input  o_Food_X, o_Food_Y, o_Valid, o_Fail, o_Busy
    );
endinterface

// File: rtl/food_placer.sv
// Food placer: draws pseudo-random grid cells from a 12-bit LFSR, rejects
// cells outside the playfield or reported occupied, and reports the first
// free cell (o_Valid) or gives up after MAX_TRIES rejections (o_Fail).
module food_placer #(
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter int          TAP1      = 4,
    parameter int          TAP2      = 7,
    parameter logic [11:0] INIT      = 12'h001,
    parameter int          MAX_TRIES = 64
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    food_placer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SAMPLE,
        S_QUERY,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    // Grid limits need 7 bits so that a 64-wide grid still compares correctly.
    localparam logic [6:0] GW    = 7'(GRID_W);
    localparam logic [6:0] GH    = 7'(GRID_H);
    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

    state_t      state;
    state_t      state_next;
    state_t      reject_next;
    logic [11:0] lfsr;
    logic [7:0]  tries;
    logic [7:0]  tries_inc;
    logic [5:0]  cand_x;
    logic [5:0]  cand_y;
    logic        in_range;
    logic        advance;
    logic        load_cand;
    logic        reject;
    logic        accept;
    logic        clear_tries;

    // One LFSR step; an all-zero register would never leave zero, so it
    // is reseeded instead of shifted.
    function automatic logic [11:0] lfsr_advance(input logic [11:0] v);
        logic [11:0] r;
        if (v == 12'h000) begin
            r = INIT;
        end else begin
            r = {v[10:0], v[TAP1] ^ v[TAP2]};
        end
        return r;
    endfunction

    assign cand_x    = lfsr[5:0];
    assign cand_y    = lfsr[11:6];
    assign in_range  = ({1'b0, cand_x} < GW) && ({1'b0, cand_y} < GH);
    assign tries_inc = tries + 8'd1;

    // Next state and per-state datapath enables; abort overrides everything.
    always_comb begin
        state_next  = state;
        advance     = 1'b0;
        load_cand   = 1'b0;
        reject      = 1'b0;
        accept      = 1'b0;
        clear_tries = 1'b0;
        reject_next = (tries_inc == MAX_T) ? S_FAIL : S_STEP;
        if (bus.i_Abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_Req) begin
                        clear_tries = 1'b1;
                        state_next  = S_STEP;
                    end
                end
                S_STEP: begin
                    advance    = 1'b1;
                    state_next = S_SAMPLE;
                end
                S_SAMPLE: begin
                    load_cand = 1'b1;
                    if (!in_range) begin
                        reject     = 1'b1;
                        state_next = reject_next;
                    end else begin
                        state_next = S_QUERY;
                    end
                end
                S_QUERY: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_Occupied) begin
                        reject     = 1'b1;
                        state_next = reject_next;
                    end else begin
                        accept     = 1'b1;
                        state_next = S_DONE;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                S_FAIL:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // LFSR only moves in STEP, so aborts and idle time leave it untouched.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            lfsr <= INIT;
        end else if (advance) begin
            lfsr <= lfsr_advance(lfsr);
        end
    end

    // Rejection counter, cleared when a new search is accepted from IDLE.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tries <= 8'd0;
        end else if (clear_tries) begin
            tries <= 8'd0;
        end else if (reject) begin
            tries <= tries_inc;
        end
    end

    // Candidate cell is latched even when it is out of range.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bus.o_Query_X <= 6'd0;
            bus.o_Query_Y <= 6'd0;
        end else if (load_cand) begin
            bus.o_Query_X <= cand_x;
            bus.o_Query_Y <= cand_y;
        end
    end

    // Food position only changes on an accepted free cell.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bus.o_Food_X <= 6'd0;
            bus.o_Food_Y <= 6'd0;
        end else if (accept) begin
            bus.o_Food_X <= bus.o_Query_X;
            bus.o_Food_Y <= bus.o_Query_Y;
        end
    end

    // Strobes and busy are registered copies of the state being entered,
    // so they line up exactly with QUERY/DONE/FAIL and cannot overlap.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bus.o_Query_Valid <= 1'b0;
            bus.o_Valid       <= 1'b0;
            bus.o_Fail        <= 1'b0;
            bus.o_Busy        <= 1'b0;
        end else begin
            bus.o_Query_Valid <= (state_next == S_QUERY);
            bus.o_Valid       <= (state_next == S_DONE);
            bus.o_Fail        <= (state_next == S_FAIL);
            bus.o_Busy        <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// Testbench for food_placer: three instances (defaults, GRID_W=3,
// MAX_TRIES=2), a table of single-search cases, hand-written multi-cycle
// sequences, and randomized occupancy maps against a behavioural model.
module tb_food_placer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [2:0] req_a, abort_a, occ_a;
    logic [2:0] qv_a, v_a, f_a, busy_a;
    logic [5:0] qx_a [3];
    logic [5:0] qy_a [3];
    logic [5:0] fx_a [3];
    logic [5:0] fy_a [3];

    food_placer_if bus0 ();
    food_placer_if bus1 ();
    food_placer_if bus2 ();

    assign bus0.i_Req = req_a[0];  assign bus0.i_Abort = abort_a[0];  assign bus0.i_Occupied = occ_a[0];
    assign bus1.i_Req = req_a[1];  assign bus1.i_Abort = abort_a[1];  assign bus1.i_Occupied = occ_a[1];
    assign bus2.i_Req = req_a[2];  assign bus2.i_Abort = abort_a[2];  assign bus2.i_Occupied = occ_a[2];

    assign qv_a[0] = bus0.o_Query_Valid; assign v_a[0] = bus0.o_Valid; assign f_a[0] = bus0.o_Fail; assign busy_a[0] = bus0.o_Busy;
    assign qv_a[1] = bus1.o_Query_Valid; assign v_a[1] = bus1.o_Valid; assign f_a[1] = bus1.o_Fail; assign busy_a[1] = bus1.o_Busy;
    assign qv_a[2] = bus2.o_Query_Valid; assign v_a[2] = bus2.o_Valid; assign f_a[2] = bus2.o_Fail; assign busy_a[2] = bus2.o_Busy;
    assign qx_a[0] = bus0.o_Query_X; assign qy_a[0] = bus0.o_Query_Y; assign fx_a[0] = bus0.o_Food_X; assign fy_a[0] = bus0.o_Food_Y;
    assign qx_a[1] = bus1.o_Query_X; assign qy_a[1] = bus1.o_Query_Y; assign fx_a[1] = bus1.o_Food_X; assign fy_a[1] = bus1.o_Food_Y;
    assign qx_a[2] = bus2.o_Query_X; assign qy_a[2] = bus2.o_Query_Y; assign fx_a[2] = bus2.o_Food_X; assign fy_a[2] = bus2.o_Food_Y;

    food_placer u_dut0 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus0));
    food_placer #(.GRID_W(3)) u_dut1 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus1));
    food_placer #(.MAX_TRIES(2)) u_dut2 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int errors = 0;

    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];
    bit          occ_map [64][64];

    // Behavioural model state
    logic [11:0] m_lfsr;
    bit          exp_ok;
    int          exp_fx, exp_fy, exp_lat;

    typedef struct {
        int n_occ;
        int exp_x;
        int exp_y;
        int exp_lat;
        int exp_nq;
    } vec_t;

    function automatic logic [11:0] pk(input int x, input int y);
        logic [5:0] a;
        logic [5:0] b;
        a = 6'(x);
        b = 6'(y);
        return {a, b};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_queries(input string name);
        check({name, " query count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({name, " query xy"}, int'(got_q[i]), int'(exp_q[i]));
    endtask

    task automatic do_reset();
        req_a = '0; abort_a = '0; occ_a = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Next LFSR value from the shift/feedback rule with the default taps.
    function automatic logic [11:0] ref_next(input logic [11:0] v);
        if (v == 12'h000) return 12'h001;
        return (v << 1) | 12'((v >> 4) & 1 ^ (v >> 7) & 1);
    endfunction

    // Predict a whole search: query list, outcome, food and latency.
    task automatic model_search(input int gw, input int gh, input int max_tries);
        int  rej;
        int  x, y;
        bit  fin;
        rej = 0; fin = 0; exp_lat = 0;
        exp_q.delete();
        while (!fin) begin
            m_lfsr = ref_next(m_lfsr);
            x = int'(m_lfsr) % 64;
            y = int'(m_lfsr) / 64;
            if (x < gw && y < gh) begin
                exp_q.push_back(pk(x, y));
                if (!occ_map[x][y]) begin
                    exp_ok = 1; exp_fx = x; exp_fy = y;
                    exp_lat += 5;
                    fin = 1;
                end else begin
                    exp_lat += 4;
                end
            end else begin
                exp_lat += 2;
            end
            if (!fin) begin
                rej++;
                if (rej == max_tries) begin
                    exp_ok = 0;
                    exp_lat += 1;
                    fin = 1;
                end
            end
        end
    endtask

    // Issue one request on instance d and follow it to its result pulse.
    // mode 0: occupancy from occ_map; mode 1: the first occ_n queries occupied.
    task automatic run_search(input int d, input int mode, input int occ_n,
                              output int lat, output bit got_v, output bit got_f);
        int nq;
        bit overlap;
        nq = 0; lat = 0; got_v = 0; got_f = 0; overlap = 0;
        got_q.delete();
        for (int w = 0; w < 10 && busy_a[d]; w++) @(negedge clk);
        req_a[d] = 1'b1;
        @(posedge clk);
        #1 req_a[d] = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (int'(qv_a[d]) + int'(v_a[d]) + int'(f_a[d]) > 1) overlap = 1;
            if (qv_a[d]) begin
                got_q.push_back({qx_a[d], qy_a[d]});
                occ_a[d] = (mode == 0) ? occ_map[qx_a[d]][qy_a[d]] : (nq < occ_n);
                nq++;
            end
            if (v_a[d] || f_a[d]) begin
                got_v = v_a[d]; got_f = f_a[d]; lat = n;
                break;
            end
        end
        check("strobes exclusive", int'(overlap), 0);
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL search timeout on dut%0d: no result in 600 cycles", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        int   lat;
        bit   gv, gf;
        int   vcyc [$];
        bit   pulse;
        int   efx, efy;

        tbl[0] = '{0, 2, 0, 5, 1};
        tbl[1] = '{1, 4, 0, 9, 2};
        tbl[2] = '{2, 8, 0, 13, 3};
        tbl[3] = '{3, 16, 0, 17, 4};
        tbl[4] = '{5, 2, 1, 25, 6};
        tbl[5] = '{7, 9, 4, 33, 8};

        // Reset state
        do_reset();
        check("reset busy", int'(busy_a[0]), 0);
        check("reset query_valid", int'(qv_a[0]), 0);
        check("reset valid", int'(v_a[0]), 0);
        check("reset fail", int'(f_a[0]), 0);
        check("reset query_xy", int'({qx_a[0], qy_a[0]}), 0);
        check("reset food_xy", int'({fx_a[0], fy_a[0]}), 0);
        check("reset busy dut1/2", int'({busy_a[1], busy_a[2]}), 0);

        // Table: fresh LFSR, first n queries occupied
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_search(0, 1, tbl[i].n_occ, lat, gv, gf);
            check("tbl valid", int'(gv), 1);
            check("tbl latency", lat, tbl[i].exp_lat);
            check("tbl queries", got_q.size(), tbl[i].exp_nq);
            check("tbl food", int'({fx_a[0], fy_a[0]}), int'(pk(tbl[i].exp_x, tbl[i].exp_y)));
        end

        // Held request: busy cycles ignore it, then it restarts after IDLE
        do_reset();
        occ_a[0] = 1'b0;
        req_a[0] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40 && vcyc.size() < 2; n++) begin
            @(negedge clk);
            if (v_a[0]) vcyc.push_back(n);
            if (n == 6) check("held req idle gap busy", int'(busy_a[0]), 0);
        end
        req_a[0] = 1'b0;
        check("held req pulses", vcyc.size(), 2);
        if (vcyc.size() == 2) begin
            check("held req first valid", vcyc[0], 5);
            check("held req second valid", vcyc[1], 11);
        end
        check("held req food", int'({fx_a[0], fy_a[0]}), int'(pk(4, 0)));

        // GRID_W=3: second search skips out-of-range candidates without querying
        do_reset();
        run_search(1, 1, 0, lat, gv, gf);
        exp_q.delete(); exp_q.push_back(pk(2, 0));
        check_queries("grid3 first");
        check("grid3 first latency", lat, 5);
        run_search(1, 1, 0, lat, gv, gf);
        exp_q.delete(); exp_q.push_back(pk(2, 1));
        check_queries("grid3 second");
        check("grid3 second latency", lat, 13);
        check("grid3 second valid", int'(gv), 1);
        check("grid3 food", int'({fx_a[1], fy_a[1]}), int'(pk(2, 1)));

        // MAX_TRIES=2 with everything occupied
        do_reset();
        run_search(2, 1, 99, lat, gv, gf);
        exp_q.delete(); exp_q.push_back(pk(2, 0)); exp_q.push_back(pk(4, 0));
        check_queries("give up");
        check("give up fail", int'(gf), 1);
        check("give up valid", int'(gv), 0);
        check("give up latency", lat, 9);
        check("give up food", int'({fx_a[2], fy_a[2]}), 0);
        @(negedge clk);
        check("give up busy after", int'(busy_a[2]), 0);

        // Abort in WAIT; next search continues from the current LFSR
        do_reset();
        occ_a[0] = 1'b0;
        req_a[0] = 1'b1;
        @(posedge clk);
        #1 req_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("abort query seen", int'(qv_a[0]), 1);
        @(negedge clk);
        abort_a[0] = 1'b1;
        @(posedge clk);
        #1 abort_a[0] = 1'b0;
        pulse = 0;
        @(negedge clk);
        check("abort busy", int'(busy_a[0]), 0);
        repeat (6) begin
            if (v_a[0] || f_a[0]) pulse = 1;
            @(negedge clk);
        end
        check("abort no pulse", int'(pulse), 0);
        check("abort food kept", int'({fx_a[0], fy_a[0]}), 0);
        run_search(0, 1, 0, lat, gv, gf);
        exp_q.delete(); exp_q.push_back(pk(4, 0));
        check_queries("after abort");
        check("after abort food", int'({fx_a[0], fy_a[0]}), int'(pk(4, 0)));

        // Reset in QUERY clears outputs immediately and reseeds the LFSR
        do_reset();
        occ_a[0] = 1'b0;
        req_a[0] = 1'b1;
        @(posedge clk);
        #1 req_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset query_valid", int'(qv_a[0]), 1);
        rst_n = 1'b0;
        #1;
        check("async reset query_valid", int'(qv_a[0]), 0);
        check("async reset busy", int'(busy_a[0]), 0);
        check("async reset query_xy", int'({qx_a[0], qy_a[0]}), 0);
        check("async reset strobes", int'({v_a[0], f_a[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse = 0;
        repeat (6) begin
            @(negedge clk);
            if (v_a[0] || f_a[0] || busy_a[0]) pulse = 1;
        end
        check("post-reset quiet", int'(pulse), 0);
        run_search(0, 1, 0, lat, gv, gf);
        exp_q.delete(); exp_q.push_back(pk(2, 0));
        check_queries("post-reset");

        // Randomized occupancy maps against the behavioural model
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < 64; x++)
                for (int y = 0; y < 64; y++)
                    occ_map[x][y] = ($urandom_range(0, 9) < 7 + r);
            do_reset();
            m_lfsr = 12'h001;
            efx = 0; efy = 0;
            for (int s = 0; s < 15; s++) begin
                model_search(40, 30, 64);
                if (exp_ok) begin efx = exp_fx; efy = exp_fy; end
                run_search(0, 0, 0, lat, gv, gf);
                check_queries("random");
                check("random valid", int'(gv), int'(exp_ok));
                check("random fail", int'(gf), int'(!exp_ok));
                check("random latency", lat, exp_lat);
                check("random food", int'({fx_a[0], fy_a[0]}), int'(pk(efx, efy)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
